// File: rtl/mem_arbiter.sv
// Two-requester memory port arbiter: fetch and data requests share one bus,
// with one pending slot per requester, alternating priority and a zero-latency completion path.
module mem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    // fetch requester
    input  logic                imem_valid,
    input  logic                imem_instr,
    input  logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_wdata,
    input  logic [DATA_W/8-1:0] imem_wstrb,
    output logic                imem_ready,
    output logic [DATA_W-1:0]   imem_rdata,
    output logic                imem_error,
    // data requester
    input  logic                dmem_valid,
    input  logic                dmem_instr,
    input  logic [ADDR_W-1:0]   dmem_addr,
    input  logic [DATA_W-1:0]   dmem_wdata,
    input  logic [DATA_W/8-1:0] dmem_wstrb,
    output logic                dmem_ready,
    output logic [DATA_W-1:0]   dmem_rdata,
    output logic                dmem_error,
    // memory bus
    output logic                bus_valid,
    output logic                bus_instr,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_wstrb,
    input  logic                bus_ready,
    input  logic [DATA_W-1:0]   bus_rdata,
    input  logic                bus_error,
    // FSM state for observation
    output logic [1:0]          dbg_state
);

    // Handshake: *_valid and bus_valid are single-cycle request pulses with no
    // back-pressure; bus_ready is a single-cycle completion pulse that is
    // passed straight through to the owning requester as *_ready in the same cycle.

    localparam int STRB_W = DATA_W / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    typedef struct packed {
        logic              instr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wstrb;
    } req_t;

    logic [1:0] state_q, state_d;
    logic       pi_valid_q, pi_valid_d;
    logic       pd_valid_q, pd_valid_d;
    req_t       pi_q, pi_d;
    req_t       pd_q, pd_d;
    logic       last_grant_q, last_grant_d;
    logic       bus_valid_q, bus_valid_d;
    req_t       bus_req_q, bus_req_d;

    req_t imem_req;
    req_t dmem_req;
    logic i_done, d_done;
    logic i_accept, d_accept;
    logic issue_win;
    logic cand_i, cand_d;
    req_t cand_i_req, cand_d_req;
    logic grant_i, grant_d;

    assign imem_req = {imem_instr, imem_addr, imem_wdata, imem_wstrb};
    assign dmem_req = {dmem_instr, dmem_addr, dmem_wdata, dmem_wstrb};

    assign i_done = (state_q == BUSY_I) && bus_ready;
    assign d_done = (state_q == BUSY_D) && bus_ready;

    // A requester may re-request in the very cycle its own transaction completes.
    assign i_accept = imem_valid && !pi_valid_q && ((state_q != BUSY_I) || i_done);
    assign d_accept = dmem_valid && !pd_valid_q && ((state_q != BUSY_D) || d_done);

    // bus_ready in IDLE is stray, so IDLE alone opens the window there.
    assign issue_win = (state_q == IDLE) || i_done || d_done;

    assign cand_i     = pi_valid_q || i_accept;
    assign cand_d     = pd_valid_q || d_accept;
    assign cand_i_req = pi_valid_q ? pi_q : imem_req;
    assign cand_d_req = pd_valid_q ? pd_q : dmem_req;

    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (issue_win) begin
            if (cand_i && cand_d) begin
                grant_d = (last_grant_q == GRANT_I);
                grant_i = (last_grant_q == GRANT_D);
            end else begin
                grant_i = cand_i;
                grant_d = cand_d;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pi_valid_d   = pi_valid_q || i_accept;
        pd_valid_d   = pd_valid_q || d_accept;
        pi_d         = i_accept ? imem_req : pi_q;
        pd_d         = d_accept ? dmem_req : pd_q;
        last_grant_d = last_grant_q;
        bus_valid_d  = 1'b0;
        bus_req_d    = bus_req_q;

        if (grant_i) begin
            bus_req_d    = cand_i_req;
            bus_valid_d  = 1'b1;
            pi_valid_d   = 1'b0;
            state_d      = BUSY_I;
            last_grant_d = GRANT_I;
        end else if (grant_d) begin
            bus_req_d    = cand_d_req;
            bus_valid_d  = 1'b1;
            pd_valid_d   = 1'b0;
            state_d      = BUSY_D;
            last_grant_d = GRANT_D;
        end else if (issue_win) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            pi_valid_q   <= 1'b0;
            pd_valid_q   <= 1'b0;
            pi_q         <= '0;
            pd_q         <= '0;
            last_grant_q <= GRANT_I;
            bus_valid_q  <= 1'b0;
            bus_req_q    <= '0;
        end else begin
            state_q      <= state_d;
            pi_valid_q   <= pi_valid_d;
            pd_valid_q   <= pd_valid_d;
            pi_q         <= pi_d;
            pd_q         <= pd_d;
            last_grant_q <= last_grant_d;
            bus_valid_q  <= bus_valid_d;
            bus_req_q    <= bus_req_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_instr = bus_req_q.instr;
    assign bus_addr  = bus_req_q.addr;
    assign bus_wdata = bus_req_q.wdata;
    assign bus_wstrb = bus_req_q.wstrb;

    assign imem_ready = i_done;
    assign imem_rdata = i_done ? bus_rdata : '0;
    assign imem_error = i_done && bus_error;

    assign dmem_ready = d_done;
    assign dmem_rdata = d_done ? bus_rdata : '0;
    assign dmem_error = d_done && bus_error;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written
// alternation and reset sequences, then random traffic against a transaction-level model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        imem_valid, imem_instr;
  logic [31:0] imem_addr, imem_wdata;
  logic [3:0]  imem_wstrb;
  logic        imem_ready, imem_error;
  logic [31:0] imem_rdata;
  logic        dmem_valid, dmem_instr;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready, dmem_error;
  logic [31:0] dmem_rdata;
  logic        bus_valid, bus_instr;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ready, bus_error;
  logic [31:0] bus_rdata;
  logic [1:0]  dbg_state;

  mem_arbiter #(.DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .imem_valid(imem_valid), .imem_instr(imem_instr), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .imem_wstrb(imem_wstrb),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .imem_error(imem_error),
    .dmem_valid(dmem_valid), .dmem_instr(dmem_instr), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
    .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_error(dmem_error),
    .bus_valid(bus_valid), .bus_instr(bus_instr), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .bus_error(bus_error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic clear_inputs();
    rst = 1'b1;
    imem_valid = 1'b0; imem_instr = 1'b0; imem_addr = '0; imem_wdata = '0; imem_wstrb = '0;
    dmem_valid = 1'b0; dmem_instr = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
    bus_ready = 1'b0; bus_rdata = '0; bus_error = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  // vector table records
  typedef struct packed {
    logic        r;
    logic        iv;
    logic [31:0] ia;
    logic        dv;
    logic [31:0] da;
    logic [3:0]  ds;
    logic [31:0] dw;
    logic        br;
    logic [31:0] brd;
    logic        be;
  } in_t;

  typedef struct packed {
    logic        bv;
    logic [31:0] ba;
    logic [3:0]  bs;
    logic        ir;
    logic [31:0] ird;
    logic        ie;
    logic        dr;
    logic [31:0] drd;
    logic        de;
  } exp_t;

  typedef struct packed {
    in_t  i;
    exp_t e;
  } vec_t;

  function automatic in_t vi(input logic r, input logic iv, input logic [31:0] ia,
                             input logic dv, input logic [31:0] da, input logic [3:0] ds,
                             input logic [31:0] dw, input logic br, input logic [31:0] brd,
                             input logic be);
    return {r, iv, ia, dv, da, ds, dw, br, brd, be};
  endfunction

  function automatic exp_t ve(input logic bv, input logic [31:0] ba, input logic [3:0] bs,
                              input logic ir, input logic [31:0] ird, input logic ie,
                              input logic dr, input logic [31:0] drd, input logic de);
    return {bv, ba, bs, ir, ird, ie, dr, drd, de};
  endfunction

  // transaction-level reference model
  typedef struct packed {
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  req_t m_req[2];
  req_t mb;
  bit   m_out[2];
  bit   m_wait[2];
  bit   m_fly;
  int   m_owner;
  int   m_last;
  bit   nxt_bv;

  task automatic model_reset();
    for (int r = 0; r < 2; r++) begin
      m_out[r] = 0; m_wait[r] = 0; m_req[r] = '0;
    end
    mb = '0; m_fly = 0; m_owner = 0; m_last = 0; nxt_bv = 0;
  endtask

  vec_t tbl[$];
  in_t  idle_in;
  in_t  cur;
  exp_t ex;
  logic [31:0] ia_cur, da_cur, exp_addr;
  bit   v[2];
  req_t rq[2];
  bit   done, br_r, be_r, rst_r;
  logic [31:0] brd_r;
  int   w;

  initial begin
    clear_inputs();
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    clear_inputs();

    idle_in = vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // idle single fetch
    tbl.push_back({idle_in, ve(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 1, 32'h100, 0, 0, 0, 0, 0, 0, 0), ve(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(1, 32'h100, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(0, 32'h100, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'hDEADBEEF, 0), ve(0, 32'h100, 0, 1, 32'hDEADBEEF, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(0, 32'h100, 0, 0, 0, 0, 0, 0, 0)});
    // simultaneous requests right after reset: data first
    tbl.push_back({vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), ve(0, 32'h100, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 1, 32'h200, 1, 32'h8000, 4'hF, 32'h12345678, 0, 0, 0), ve(0, 0, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(1, 32'h8000, 4'hF, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'h55, 0), ve(0, 32'h8000, 4'hF, 0, 0, 0, 1, 32'h55, 0)});
    tbl.push_back({idle_in, ve(1, 32'h200, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'h66, 0), ve(0, 32'h200, 0, 1, 32'h66, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(0, 32'h200, 0, 0, 0, 0, 0, 0, 0)});
    // data error
    tbl.push_back({vi(1, 0, 0, 1, 32'h9000, 0, 0, 0, 0, 0), ve(0, 32'h200, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(1, 32'h9000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'hBAD0, 1), ve(0, 32'h9000, 0, 0, 0, 0, 1, 32'hBAD0, 1)});
    // stray response in IDLE
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'h1234, 1), ve(0, 32'h9000, 0, 0, 0, 0, 0, 0, 0)});
    // duplicate data requests while in flight
    tbl.push_back({vi(1, 0, 0, 1, 32'hA000, 0, 0, 0, 0, 0), ve(0, 32'h9000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 1, 32'hA004, 0, 0, 0, 0, 0), ve(1, 32'hA000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 1, 32'hA008, 0, 0, 0, 0, 0), ve(0, 32'hA000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'h77, 0), ve(0, 32'hA000, 0, 0, 0, 0, 1, 32'h77, 0)});
    tbl.push_back({idle_in, ve(0, 32'hA000, 0, 0, 0, 0, 0, 0, 0)});
    // re-request in the cycle of own completion is accepted
    tbl.push_back({vi(1, 0, 0, 1, 32'hB000, 0, 0, 0, 0, 0), ve(0, 32'hA000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({idle_in, ve(1, 32'hB000, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 1, 32'hB004, 4'h3, 0, 1, 32'h88, 0), ve(0, 32'hB000, 0, 0, 0, 0, 1, 32'h88, 0)});
    tbl.push_back({idle_in, ve(1, 32'hB004, 4'h3, 0, 0, 0, 0, 0, 0)});
    tbl.push_back({vi(1, 0, 0, 0, 0, 0, 0, 1, 32'h99, 0), ve(0, 32'hB004, 4'h3, 0, 0, 0, 1, 32'h99, 0)});
    tbl.push_back({idle_in, ve(0, 32'hB004, 4'h3, 0, 0, 0, 0, 0, 0)});

    for (int k = 0; k < tbl.size(); k++) begin
      cur = tbl[k].i;
      ex  = tbl[k].e;
      rst = cur.r;
      imem_valid = cur.iv; imem_instr = cur.iv; imem_addr = cur.ia;
      dmem_valid = cur.dv; dmem_addr = cur.da; dmem_wstrb = cur.ds; dmem_wdata = cur.dw;
      bus_ready = cur.br; bus_rdata = cur.brd; bus_error = cur.be;
      @(negedge clk);
      chk($sformatf("row%0d bus_valid", k), bus_valid, ex.bv);
      chk($sformatf("row%0d bus_addr", k), bus_addr, ex.ba);
      chk($sformatf("row%0d bus_wstrb", k), bus_wstrb, ex.bs);
      chk($sformatf("row%0d imem_ready", k), imem_ready, ex.ir);
      chk($sformatf("row%0d imem_rdata", k), imem_rdata, ex.ird);
      chk($sformatf("row%0d imem_error", k), imem_error, ex.ie);
      chk($sformatf("row%0d dmem_ready", k), dmem_ready, ex.dr);
      chk($sformatf("row%0d dmem_rdata", k), dmem_rdata, ex.drd);
      chk($sformatf("row%0d dmem_error", k), dmem_error, ex.de);
      next_cycle();
    end

    // alternation: both slots kept full, grants must go D, I, D, I, D, I
    rst = 1'b0;
    next_cycle();
    ia_cur = 32'h1000;
    da_cur = 32'h2000;
    imem_valid = 1'b1; imem_addr = ia_cur;
    dmem_valid = 1'b1; dmem_addr = da_cur;
    next_cycle();
    for (int t = 0; t < 6; t++) begin
      exp_addr = (t % 2 == 0) ? da_cur : ia_cur;
      @(negedge clk);
      chk($sformatf("alt%0d bus_valid", t), bus_valid, 1'b1);
      chk($sformatf("alt%0d bus_addr", t), bus_addr, exp_addr);
      next_cycle();
      bus_ready = 1'b1;
      bus_rdata = 32'(t + 1);
      if (t % 2 == 0) begin
        da_cur = da_cur + 32'd4;
        dmem_valid = 1'b1; dmem_addr = da_cur;
      end else begin
        ia_cur = ia_cur + 32'd4;
        imem_valid = 1'b1; imem_addr = ia_cur;
      end
      @(negedge clk);
      chk($sformatf("alt%0d dmem_ready", t), dmem_ready, (t % 2 == 0) ? 1'b1 : 1'b0);
      chk($sformatf("alt%0d imem_ready", t), imem_ready, (t % 2 == 1) ? 1'b1 : 1'b0);
      chk($sformatf("alt%0d rdata", t), imem_rdata | dmem_rdata, 32'(t + 1));
      next_cycle();
    end

    // reset while a fetch is in flight and the data slot is full
    rst = 1'b0;
    next_cycle();
    imem_valid = 1'b1; imem_addr = 32'h300;
    next_cycle();
    dmem_valid = 1'b1; dmem_addr = 32'h400;
    @(negedge clk);
    chk("rmf fetch issued", bus_addr, 32'h300);
    next_cycle();
    rst = 1'b0;
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'hFFFF; bus_error = 1'b1;
    @(negedge clk);
    chk("rmf bus_valid", bus_valid, 1'b0);
    chk("rmf bus_addr", bus_addr, 32'h0);
    chk("rmf bus_wdata", bus_wdata, 32'h0);
    chk("rmf bus_wstrb", bus_wstrb, 4'h0);
    chk("rmf bus_instr", bus_instr, 1'b0);
    chk("rmf imem_ready", imem_ready, 1'b0);
    chk("rmf imem_rdata", imem_rdata, 32'h0);
    chk("rmf dmem_ready", dmem_ready, 1'b0);
    chk("rmf dmem_error", dmem_error, 1'b0);
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("rmf quiet%0d bus_valid", k), bus_valid, 1'b0);
      next_cycle();
    end
    imem_valid = 1'b1; imem_addr = 32'h500;
    next_cycle();
    @(negedge clk);
    chk("rmf new bus_valid", bus_valid, 1'b1);
    chk("rmf new bus_addr", bus_addr, 32'h500);
    next_cycle();
    bus_ready = 1'b1; bus_rdata = 32'hCAFE;
    @(negedge clk);
    chk("rmf new imem_ready", imem_ready, 1'b1);
    chk("rmf new imem_rdata", imem_rdata, 32'hCAFE);
    next_cycle();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("rmf drop%0d bus_valid", k), bus_valid, 1'b0);
      next_cycle();
    end

    // random traffic against the reference model
    rst = 1'b0;
    next_cycle();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int r = 0; r < 2; r++) begin
        v[r] = ($urandom_range(0, 3) == 0);
        rq[r] = {1'($urandom_range(0, 1)), 32'($urandom), 32'($urandom), 4'($urandom_range(0, 15))};
      end
      br_r  = ($urandom_range(0, 2) == 0);
      brd_r = $urandom;
      be_r  = ($urandom_range(0, 3) == 0);
      rst_r = ($urandom_range(0, 199) != 0);
      rst = rst_r;
      imem_valid = v[0]; imem_instr = rq[0].instr; imem_addr = rq[0].addr;
      imem_wdata = rq[0].wdata; imem_wstrb = rq[0].wstrb;
      dmem_valid = v[1]; dmem_instr = rq[1].instr; dmem_addr = rq[1].addr;
      dmem_wdata = rq[1].wdata; dmem_wstrb = rq[1].wstrb;
      bus_ready = br_r; bus_rdata = brd_r; bus_error = be_r;
      @(negedge clk);
      done = m_fly && br_r;
      chk("rnd bus_valid", bus_valid, nxt_bv);
      chk("rnd bus_instr", bus_instr, mb.instr);
      chk("rnd bus_addr", bus_addr, mb.addr);
      chk("rnd bus_wdata", bus_wdata, mb.wdata);
      chk("rnd bus_wstrb", bus_wstrb, mb.wstrb);
      chk("rnd imem_ready", imem_ready, done && m_owner == 0);
      chk("rnd imem_rdata", imem_rdata, (done && m_owner == 0) ? brd_r : 32'h0);
      chk("rnd imem_error", imem_error, done && m_owner == 0 && be_r);
      chk("rnd dmem_ready", dmem_ready, done && m_owner == 1);
      chk("rnd dmem_rdata", dmem_rdata, (done && m_owner == 1) ? brd_r : 32'h0);
      chk("rnd dmem_error", dmem_error, done && m_owner == 1 && be_r);

      if (!rst_r) begin
        model_reset();
      end else begin
        nxt_bv = 0;
        if (done) begin
          m_out[m_owner] = 0;
          m_fly = 0;
        end
        for (int r = 0; r < 2; r++) begin
          if (v[r] && !m_out[r]) begin
            m_out[r] = 1; m_wait[r] = 1; m_req[r] = rq[r];
          end
        end
        if (!m_fly) begin
          w = -1;
          if (m_wait[0] && m_wait[1]) w = 1 - m_last;
          else if (m_wait[0]) w = 0;
          else if (m_wait[1]) w = 1;
          if (w >= 0) begin
            mb = m_req[w]; nxt_bv = 1; m_fly = 1;
            m_owner = w; m_wait[w] = 0; m_last = w;
          end
        end
      end
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
